// File: rtl/led_arbiter.sv
// Round-robin time-sliced owner of the six status LEDs: SHOW a latched pattern, then GAP blank.
// Grant 1 cycle after req is sampled in IDLE; no backpressure, losers just wait for a later IDLE.
module led_arbiter #(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 200,
  parameter int GAP_TICKS  = 20
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [23:0] pat_in,
  output logic [3:0]  gnt,
  output logic        done,
  output logic        busy,
  output logic        led0,
  output logic        led1,
  output logic        led2,
  output logic        led3,
  output logic        led4,
  output logic        led5
);

  localparam int MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int PW   = $clog2(TICK_DIV);
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [5:0]    pat_q, pat_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [5:0]    led_q, led_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic          tick;
  logic          win_vld;
  logic [1:0]    win_idx;

  assign tick = (pre_q == PRE_LAST);

  // Search pointer+1, +2, +3, +4 (mod 4) so the last winner comes last.
  always_comb begin
    logic [1:0] cand;
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = tick ? '0 : pre_q + 1'b1;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    pat_d   = pat_q;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SHOW;
          ptr_d   = win_idx;
          pat_d   = pat_in[win_idx*6 +: 6];
        end
      end
      SHOW: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if ((tick && cnt_q == HOLD_LAST) || !req[ptr_q]) state_d = GAP;
      end
      GAP: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (tick && cnt_q == GAP_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Every state starts from a clean tick boundary.
    if (state_d != state_q) begin
      pre_d = '0;
      cnt_d = '0;
    end

    gnt_d  = (state_d == SHOW) ? (4'b0001 << ptr_d) : 4'b0000;
    led_d  = (state_d == SHOW) ? pat_d : 6'b000000;
    busy_d = (state_d != IDLE);
    done_d = (state_q == SHOW) && (state_d == GAP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      pat_q   <= '0;
      gnt_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      pat_q   <= pat_d;
      gnt_q   <= gnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign led0 = led_q[0];
  assign led1 = led_q[1];
  assign led2 = led_q[2];
  assign led3 = led_q[3];
  assign led4 = led_q[4];
  assign led5 = led_q[5];

endmodule
